edge_debouncer: RTL
===================

EDGE_DEBOUNCER -- requirements
Module: edge_debouncer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of independent input channels (WIDTH >= 1).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive cycles a changed input must hold before it is accepted (STABLE_CYCLES >= 1).
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port in, input, WIDTH bits, the raw asynchronous/bouncy channel inputs.
REQ-006 The block SHALL have port mode, input, 2 bits, the event select: 00 none, 01 rising, 10 falling, 11 both.
REQ-007 The block SHALL have port level, output, WIDTH bits, the debounced stable level per channel.
REQ-008 The block SHALL have port out, output, WIDTH bits, a one-cycle event pulse per channel.
REQ-009 The block SHALL have port any_event, output, 1 bit, the OR of all out bits.

Function
REQ-010 Each channel SHALL hold a sample s (in[i], or its synchronised copy per REQ-021), a level register and a counter of width $clog2(STABLE_CYCLES+1).
REQ-011 Per edge, when s equals level, the counter SHALL load 0.
REQ-012 Per edge, when s differs from level and counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 Per edge, when s differs from level and counter == STABLE_CYCLES-1, level SHALL load s, the counter SHALL load 0, and a channel event SHALL be raised.
REQ-014 With REQ-011 to REQ-013, a change held for STABLE_CYCLES consecutive edges SHALL appear on level at the STABLE_CYCLES-th edge; a shorter glitch SHALL leave level unchanged and restart the count.
REQ-015 out[i] SHALL be registered and asserted for exactly the edge on which level[i] updates, qualified as follows: asserted on a 0->1 update when mode is 01 or 11; asserted on a 1->0 update when mode is 10 or 11; otherwise 0.
REQ-016 mode SHALL be sampled on the same edge as the level update; mode changes SHALL never alter level or the counters.
REQ-017 With STABLE_CYCLES == 1, level SHALL follow s with one cycle latency, and out SHALL pulse on every accepted change.
REQ-018 Channels SHALL be fully independent; simultaneous events SHALL assert multiple out bits in the same cycle, with any_event high for that single cycle.
REQ-019 any_event SHALL be registered, in the same cycle as out.

Reset
REQ-020 While reset is high at an edge, level, out, any_event, all counters and all synchroniser flops SHALL become 0; reset mid-count SHALL discard the partial count. After release with in high, a full STABLE_CYCLES count SHALL run and then produce a rising event.

Configuration
REQ-021 When macro EDGE_DEBOUNCER_SYNC_EN is defined, each in bit SHALL pass through a two-flop synchroniser before sampling, adding exactly 2 cycles to all latencies.
REQ-022 When EDGE_DEBOUNCER_SYNC_EN is undefined, s SHALL be in directly, with no added flops.

Structure
REQ-023 Package debounce_pkg SHALL hold the 2-bit mode typedef and the constants MODE_NONE, MODE_RISE, MODE_FALL and MODE_BOTH.
REQ-024 Per-channel logic SHALL live in sub-module debounce_channel, instantiated WIDTH times by a generate loop; any_event is formed at the top level.

Verification (WIDTH=4, STABLE_CYCLES=4, macro undefined unless stated)
REQ-025 Stimulus: mode=01, in[0] 0->1 held 10 cycles. Required: level[0] rises at the 4th edge; out[0] and any_event are high for exactly that one cycle.
REQ-026 Stimulus: in[1] pulsed high for 3 cycles, then low. Required: level[1] stays 0 and out stays 0.
REQ-027 Stimulus: mode=10, in[2] raised and then dropped, each held 6 cycles. Required: level[2] follows both changes; out[2] pulses only on the fall.
REQ-028 Stimulus: mode=11, in[0] and in[3] change on the same cycle. Required: out = 4'b1001 for one cycle and any_event is high for one cycle.
REQ-029 Stimulus: reset asserted while the counter is at 2, in held high. Required: all outputs are 0; the level rise comes 4 edges after reset release.
REQ-030 Stimulus: EDGE_DEBOUNCER_SYNC_EN defined, scenario REQ-025 repeated. Required: level[0] rises at the 6th edge after the change.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types for the edge debouncer: event-select mode encoding and its decode helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

  // Bit 0 of the mode enables rising events, bit 1 enables falling events.
  function automatic logic event_en(input mode_t mode, input logic rising);
    logic [1:0] m;
    m = mode;
    return rising ? m[0] : m[1];
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: level accepted after STABLE_CYCLES steady edges; 1-cycle qualified event pulse.
// Optional two-flop input synchroniser under EDGE_DEBOUNCER_SYNC_EN (adds 2 cycles); no backpressure.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  raw,
  input  mode_t mode,
  output logic  level,
  output logic  pulse,
  output logic  pulse_nxt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          s;
  logic [CW-1:0] cnt;
  logic          accept;

`ifdef EDGE_DEBOUNCER_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = raw;
`endif

  assign accept    = (s != level) && (cnt == LAST);
  assign pulse_nxt = accept && event_en(mode, s);

  always_ff @(posedge clock) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= pulse_nxt;
      if (s == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_debouncer.sv
// WIDTH independent debounced channels with mode-qualified event pulses and a registered any_event.
// Latency STABLE_CYCLES edges (+2 with EDGE_DEBOUNCER_SYNC_EN defined); no backpressure.
module edge_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] out,
  output logic             any_event
);

  logic [WIDTH-1:0] out_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .raw      (in[i]),
      .mode     (mode_t'(mode)),
      .level    (level[i]),
      .pulse    (out[i]),
      .pulse_nxt(out_nxt[i])
    );
  end

  // Registered from the channels' next-pulse terms so it lines up with out.
  always_ff @(posedge clock) begin
    if (reset) any_event <= 1'b0;
    else       any_event <= |out_nxt;
  end

endmodule
